// File: rtl/jk_pkg.sv
// Shared types for the JK command driver: opcode and state enums,
// opcode width and the opcode-to-{j,k} decode helper.
package jk_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } jk_state_e;

    // Returns {j,k} for an opcode.
    function automatic logic [1:0] jk_decode(jk_op_e op);
        logic [1:0] jk;
        jk = 2'b00;
        unique case (op)
            JK_HOLD:   jk = 2'b00;
            JK_RESET:  jk = 2'b01;
            JK_SET:    jk = 2'b10;
            JK_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_model_chk.sv
// Behavioural model of the downstream JK flip-flop with a sticky
// mismatch flag against the fed-back q.
// Ports: clk, rstn (async, active-low), j/k (driven values),
//        q_fb (flip-flop q), err (sticky mismatch).
module jk_model_chk (
    input  logic clk,
    input  logic rstn,
    input  logic j,
    input  logic k,
    input  logic q_fb,
    output logic err
);

    logic q_exp_q, q_exp_d;
    logic err_q, err_d;

    always_comb begin
        q_exp_d = (j & ~q_exp_q) | (~k & q_exp_q);
        // Model and real flop update on the same edge, so compare
        // the pre-edge values of both.
        err_d   = err_q | (q_fb ^ q_exp_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_exp_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_exp_q <= q_exp_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/jk_cmd_driver.sv
// Command-driven J/K stimulus stage: holds the decoded {j,k} for
// len+1 cycles per accepted command, then returns to HOLD.
// Ports: clk, rstn (async, active-low), cmd_valid/cmd_ready/cmd_op/
//        cmd_len (command handshake), j/k (registered drive),
//        busy, done (one-cycle end pulse), q_fb, err (checker).
// Optional macro JK_CMD_CHECK_EN adds the flip-flop model checker;
// without it err is 0 and q_fb is ignored.
import jk_pkg::*;

module jk_cmd_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    input  logic             q_fb,
    output logic             err
);

    jk_state_e        state_q, state_d;
    jk_op_e           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    // Ready depends on state/count only, never on cmd_valid.
    assign cmd_ready = (state_q == ST_IDLE) || (cnt_q == '0);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_DRIVE;
                    op_d       = jk_op_e'(cmd_op);
                    cnt_d      = cmd_len;
                    {j_d, k_d} = jk_decode(jk_op_e'(cmd_op));
                    busy_d     = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    {j_d, k_d} = jk_decode(op_q);
                end else begin
                    // Last drive cycle: end of this command either way.
                    done_d = 1'b1;
                    if (accept) begin
                        op_d       = jk_op_e'(cmd_op);
                        cnt_d      = cmd_len;
                        {j_d, k_d} = jk_decode(jk_op_e'(cmd_op));
                        busy_d     = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        op_d       = JK_HOLD;
                        {j_d, k_d} = 2'b00;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            op_q    <= JK_HOLD;
            cnt_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign j    = j_q;
    assign k    = k_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef JK_CMD_CHECK_EN
    jk_model_chk u_chk (
        .clk  (clk),
        .rstn (rstn),
        .j    (j_q),
        .k    (k_q),
        .q_fb (q_fb),
        .err  (err)
    );
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Randomized bench for jk_cmd_driver against a per-cycle schedule
// model; also models the downstream JK flip-flop feeding q_fb.
module tb_jk_cmd_driver;

`ifdef JK_CMD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int CNT_W = 8;
    localparam int NC    = 8192;

    logic             clk;
    logic             rstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic             j, k, busy, done, q_fb, err;

    logic q_ff;
    logic inj;

    jk_cmd_driver #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .q_fb      (q_fb),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream JK flip-flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q_ff <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign q_fb = q_ff ^ inj;

    // Expected outputs per cycle; cycle c is the period after edge c.
    bit [1:0] m_jk   [NC];
    bit       m_busy [NC];
    bit       m_done [NC];
    int       last_drive;
    bit       err_exp;
    int       cyc;
    int       errs;
    int       checks;
    bit [1:0] jk_of_op [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic schedule(int op, int len);
        int c;
        c = cyc;
        for (int i = 0; i <= len; i++) begin
            m_jk[c+i]   = jk_of_op[op];
            m_busy[c+i] = 1'b1;
        end
        m_done[c+len+1] = 1'b1;
        last_drive      = c + len;
    endtask

    task automatic clear_model();
        for (int i = cyc; i < NC; i++) begin
            m_jk[i]   = 2'b00;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
        last_drive = -1;
        err_exp    = 1'b0;
    endtask

    task automatic check_cycle();
        chk("jk", {30'd0, j, k}, {30'd0, m_jk[cyc]});
        chk("busy", {31'd0, busy}, {31'd0, m_busy[cyc]});
        chk("done", {31'd0, done}, {31'd0, m_done[cyc]});
        chk("ready", {31'd0, cmd_ready}, {31'd0, last_drive <= cyc});
        chk("err", {31'd0, err}, {31'd0, err_exp});
    endtask

    // Called just after a falling edge; checks, crosses one rising edge.
    task automatic tick();
        bit acc;
        bit inj_s;
        int op_s;
        int len_s;
        check_cycle();
        acc   = rstn && cmd_valid && (last_drive <= cyc);
        inj_s = inj;
        op_s  = int'(cmd_op);
        len_s = int'(cmd_len);
        @(posedge clk);
        cyc++;
        if (acc) schedule(op_s, len_s);
        if (rstn && inj_s && CHK) err_exp = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        cmd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(int op, int len);
        bit acc_now;
        cmd_op    = op[1:0];
        cmd_len   = len[CNT_W-1:0];
        cmd_valid = 1'b1;
        for (int t = 0; t < 600; t++) begin
            acc_now = (last_drive <= cyc);
            tick();
            if (acc_now) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        inj       = 1'b0;
        rstn      = 1'b0;
        #1;
        clear_model();
        chk("rst_jk", {30'd0, j, k}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int r;
        errs       = 0;
        checks     = 0;
        cyc        = 0;
        last_drive = -1;
        err_exp    = 1'b0;
        rstn       = 1'b0;
        inj        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_len    = '0;
        @(negedge clk);
        tick();
        tick();
        rstn = 1'b1;
        idle(2);

        send(2, 3);
        idle(6);
        chk("set_q", {31'd0, q_ff}, 32'd1);

        send(1, 0);
        idle(3);
        chk("reset_q", {31'd0, q_ff}, 32'd0);
        send(3, 4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("tog_q", {31'd0, q_ff}, i % 2);
        end
        idle(4);
        chk("tog_q_end", {31'd0, q_ff}, 32'd1);

        send(2, 1);
        send(1, 0);
        idle(4);
        chk("b2b_q", {31'd0, q_ff}, 32'd0);

        send(0, 255);
        idle(260);

        send(3, 5);
        tick();
        do_reset();
        idle(3);

        send(2, 0);
        idle(2);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        idle(5);
        do_reset();
        idle(2);

        for (int it = 0; it < 3000 && cyc < NC - 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 4) begin
                inj = 1'b1;
                tick();
                inj = 1'b0;
            end else begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_op    = 2'($urandom);
                if ($urandom_range(0, 19) == 0)
                    cmd_len = CNT_W'($urandom_range(0, 255));
                else
                    cmd_len = CNT_W'($urandom_range(0, 6));
                tick();
            end
        end
        cmd_valid = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
